sccb_init_seq: RTL and testbench

- Table-driven SCCB configuration sequencer. It sits directly upstream of the SCCB master and drives that master's Start/DataIn/Busy handshake.
- It walks a synchronous-read register ROM of {reg_addr, reg_data} entries and issues one SCCB 3-phase write per entry, with a programmable inter-write gap, delay entries and an end marker.
- It brings the camera up without CPU involvement once cam_rstn deasserts. The APB path can still use the SCCB master when this block is idle (mux outside this block, selected by seq_busy).

---
 rtl/sccb_init_seq.sv | 201 ++++++++++++++++++++
 tb/tb_sccb_init_seq.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_init_seq.sv
// Table-driven SCCB bring-up sequencer: walks a {reg_addr, reg_data} ROM and
// issues one SCCB write per entry, with delay entries, an end marker and timeouts.
module sccb_init_seq #(
    parameter int          ADDR_W   = 8,
    parameter logic [7:0]  DEV_ID   = 8'h42,
    parameter logic [1:0]  WR_OP    = 2'b00,
    parameter logic [7:0]  DLY_ADDR = 8'hF0,
    parameter int          TICK_DIV = 100000,
    parameter int          GAP_CYC  = 16,
    parameter int          ACK_TO   = 8,
    parameter int          XFER_TO  = 2000000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              go,
    output logic [ADDR_W-1:0] tbl_addr,
    input  logic [15:0]       tbl_data,
    output logic              sccb_start,
    output logic [25:0]       sccb_cmd,
    input  logic              sccb_busy,
    output logic              seq_busy,
    output logic              seq_done,
    output logic              seq_err,
    output logic [ADDR_W:0]   wr_count
);

    localparam int TMR_MAX = (XFER_TO > ACK_TO) ? ((XFER_TO > GAP_CYC) ? XFER_TO : GAP_CYC)
                                                : ((ACK_TO > GAP_CYC) ? ACK_TO : GAP_CYC);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int DLY_MAX = 255 * TICK_DIV;
    localparam int DLY_W   = $clog2(DLY_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_ROMWAIT = 4'd2,
        S_DECODE  = 4'd3,
        S_ISSUE   = 4'd4,
        S_ACKWAIT = 4'd5,
        S_XFER    = 4'd6,
        S_GAP     = 4'd7,
        S_DELAY   = 4'd8,
        S_DONE    = 4'd9,
        S_ERROR   = 4'd10
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         data_q, data_d;
    logic [25:0]         cmd_q, cmd_d;
    logic                start_q, start_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [DLY_W-1:0]    dly_q, dly_d;
    logic [ADDR_W:0]     wr_cnt_q, wr_cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    state_t              adv_state_s;
    logic [ADDR_W-1:0]   adv_addr_s;

    // State and output registers; async reset aborts any transfer at once.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            cmd_q    <= '0;
            start_q  <= 1'b0;
            tmr_q    <= '0;
            dly_q    <= '0;
            wr_cnt_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            cmd_q    <= cmd_d;
            start_q  <= start_d;
            tmr_q    <= tmr_d;
            dly_q    <= dly_d;
            wr_cnt_q <= wr_cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Next-state logic; sccb_start is decided one cycle early so it is a clean flop output.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        data_d   = data_q;
        cmd_d    = cmd_q;
        start_d  = 1'b0;
        tmr_d    = tmr_q;
        dly_d    = dly_q;
        wr_cnt_d = wr_cnt_q;

        // Leaving the last table slot ends the run without an error.
        adv_state_s = (addr_q == {ADDR_W{1'b1}}) ? S_DONE : S_FETCH;
        adv_addr_s  = (addr_q == {ADDR_W{1'b1}}) ? addr_q : addr_q + ADDR_W'(1);

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (go) begin
                    addr_d   = '0;
                    wr_cnt_d = '0;
                    state_d  = S_FETCH;
                end else begin
                    state_d  = state_q;
                end
            end
            S_FETCH:   state_d = S_ROMWAIT;
            S_ROMWAIT: begin
                data_d  = tbl_data;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (data_q == 16'hFFFF) begin
                    state_d = S_DONE;
                end else if (data_q[15:8] == DLY_ADDR) begin
                    if (data_q[7:0] == 8'h00) begin
                        state_d = adv_state_s;
                        addr_d  = adv_addr_s;
                    end else begin
                        dly_d   = DLY_W'(data_q[7:0]) * DLY_W'(TICK_DIV);
                        state_d = S_DELAY;
                    end
                end else begin
                    cmd_d   = {WR_OP, DEV_ID, data_q};
                    start_d = !sccb_busy;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Without a pulse in flight, wait here while another master owns the bus.
                if (start_q) begin
                    tmr_d   = TMR_W'(1);
                    state_d = S_ACKWAIT;
                end else if (!sccb_busy) begin
                    start_d = 1'b1;
                end else begin
                    start_d = 1'b0;
                end
            end
            S_ACKWAIT: begin
                if (sccb_busy) begin
                    tmr_d   = '0;
                    state_d = S_XFER;
                end else if (tmr_q == TMR_W'(ACK_TO - 1)) begin
                    state_d = S_ERROR;
                end else begin
                    tmr_d   = tmr_q + TMR_W'(1);
                end
            end
            S_XFER: begin
                if (!sccb_busy) begin
                    wr_cnt_d = wr_cnt_q + (ADDR_W + 1)'(1);
                    tmr_d    = '0;
                    state_d  = S_GAP;
                end else if (tmr_q == TMR_W'(XFER_TO - 1)) begin
                    state_d  = S_ERROR;
                end else begin
                    tmr_d    = tmr_q + TMR_W'(1);
                end
            end
            S_GAP: begin
                if (tmr_q == TMR_W'(GAP_CYC - 1)) begin
                    state_d = adv_state_s;
                    addr_d  = adv_addr_s;
                end else begin
                    tmr_d   = tmr_q + TMR_W'(1);
                end
            end
            S_DELAY: begin
                if (dly_q == DLY_W'(1)) begin
                    state_d = adv_state_s;
                    addr_d  = adv_addr_s;
                end else begin
                    dly_d   = dly_q - DLY_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = !((state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_ERROR));
        done_d = (state_d == S_DONE);
        err_d  = (state_d == S_ERROR);
    end

    assign tbl_addr   = addr_q;
    assign sccb_start = start_q;
    assign sccb_cmd   = cmd_q;
    assign seq_busy   = busy_q;
    assign seq_done   = done_q;
    assign seq_err    = err_q;
    assign wr_count   = wr_cnt_q;

endmodule

// File: tb/tb_sccb_init_seq.sv
// Self-checking bench for sccb_init_seq: directed scenarios plus randomized ROMs,
// compared against a cycle-arithmetic model of the sequencer's timing rules.
module tb_sccb_init_seq;

    localparam int GAP  = 16;
    localparam int TICK = 10;
    localparam int ACKT = 8;
    localparam int XTO  = 100;

    logic        clk = 1'b0;
    logic        rstn;
    logic        go;
    logic [1:0]  tbl_addr;
    logic [15:0] tbl_data = 16'h0000;
    logic        sccb_start;
    logic [25:0] sccb_cmd;
    logic        sccb_busy;
    logic        seq_busy, seq_done, seq_err;
    logic [2:0]  wr_count;

    sccb_init_seq #(
        .ADDR_W(2), .DEV_ID(8'h42), .WR_OP(2'b00), .DLY_ADDR(8'hF0),
        .TICK_DIV(TICK), .GAP_CYC(GAP), .ACK_TO(ACKT), .XFER_TO(XTO)
    ) dut (
        .clk(clk), .rstn(rstn), .go(go), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .sccb_start(sccb_start), .sccb_cmd(sccb_cmd), .sccb_busy(sccb_busy),
        .seq_busy(seq_busy), .seq_done(seq_done), .seq_err(seq_err), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read ROM.
    logic [15:0] rom [4];
    always @(posedge clk) tbl_data <= rom[tbl_addr];

    // SCCB master model: mode 0 normal, 1 never acknowledges, 2 busy stuck high.
    logic m_busy = 1'b0;
    int   m_cnt  = 0;
    int   mode;
    int   blen;
    logic m_clr;
    logic ext_busy;
    always @(posedge clk) begin
        if (m_clr) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
        end else if (sccb_start && mode != 1) begin
            m_busy <= 1'b1;
            m_cnt  <= blen;
        end else if (m_busy && mode != 2) begin
            if (m_cnt <= 1) m_busy <= 1'b0;
            m_cnt <= m_cnt - 1;
        end
    end
    assign sccb_busy = m_busy | ext_busy;

    // Start monitor, sampled on the falling edge.
    int          st_cyc [$];
    logic [25:0] st_cmd [$];
    always @(negedge clk) begin
        if (sccb_start) begin
            st_cyc.push_back(cyc);
            st_cmd.push_back(sccb_cmd);
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference model: expected start cycles/commands, done cycle, write count.
    int          exp_cyc [$];
    logic [25:0] exp_cmd [$];
    int          exp_done;
    int          exp_wr;
    int          last_g;
    int          last_base;

    task automatic model_run(input int g, input int b);
        int t;
        exp_cyc.delete();
        exp_cmd.delete();
        exp_wr = 0;
        t = g + 1;
        for (int a = 0; a < 4; a++) begin
            if (rom[a] == 16'hFFFF) begin
                exp_done = t + 3;
                return;
            end
            if (rom[a][15:8] == 8'hF0) begin
                t = t + 3 + int'(rom[a][7:0]) * TICK;
            end else begin
                exp_cyc.push_back(t + 3);
                exp_cmd.push_back({2'b00, 8'h42, rom[a]});
                exp_wr++;
                t = t + 3 + b + 2 + GAP;
            end
        end
        exp_done = t;
    endtask

    task automatic pulse_go(output int g);
        @(negedge clk);
        go = 1'b1;
        g  = cyc;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_end(input int lim, output int c);
        int n;
        n = 0;
        @(negedge clk);
        while (!seq_done && !seq_err && n < lim) begin
            @(negedge clk);
            n++;
        end
        c = cyc;
    endtask

    task automatic clear_model();
        @(negedge clk);
        m_clr = 1'b1;
        @(negedge clk);
        m_clr = 1'b0;
    endtask

    task automatic run_normal(input string tag, input int b);
        int g, c;
        mode = 0;
        blen = b;
        clear_model();
        last_base = st_cyc.size();
        pulse_go(g);
        last_g = g;
        check({tag, "_busy_rise"}, seq_busy, 1);
        check({tag, "_addr0"}, tbl_addr, 0);
        model_run(g, b);
        wait_end(3000, c);
        check({tag, "_done_cyc"}, c, exp_done);
        check({tag, "_nstart"}, st_cyc.size() - last_base, exp_cyc.size());
        for (int i = 0; i < exp_cyc.size(); i++) begin
            if (last_base + i < st_cyc.size()) begin
                check({tag, "_start_cyc"}, st_cyc[last_base + i], exp_cyc[i]);
                check({tag, "_cmd"}, st_cmd[last_base + i], exp_cmd[i]);
            end
        end
        check({tag, "_wr_count"}, wr_count, exp_wr);
        check({tag, "_done"}, seq_done, 1);
        check({tag, "_err"}, seq_err, 0);
        check({tag, "_idle"}, seq_busy, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_addr"}, tbl_addr, 0);
        check({tag, "_start"}, sccb_start, 0);
        check({tag, "_cmd"}, sccb_cmd, 0);
        check({tag, "_busy"}, seq_busy, 0);
        check({tag, "_done"}, seq_done, 0);
        check({tag, "_err"}, seq_err, 0);
        check({tag, "_wr"}, wr_count, 0);
    endtask

    initial begin
        int g, s, base;
        rstn = 1'b0; go = 1'b0; ext_busy = 1'b0; m_clr = 1'b1; mode = 0; blen = 50;
        rom[0] = 16'h1280; rom[1] = 16'h1101; rom[2] = 16'hFFFF; rom[3] = 16'h0000;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rstn = 1'b1;
        m_clr = 1'b0;

        // Two writes then end marker.
        run_normal("basic", 50);
        check("basic_spacing", (st_cyc.size() >= last_base + 2) ?
              st_cyc[last_base + 1] - st_cyc[last_base] : -1, 50 + 1 + GAP + 4);

        // Delay entry of 3 ticks.
        rom[0] = 16'hF003; rom[1] = 16'h3A04; rom[2] = 16'hFFFF; rom[3] = 16'h0000;
        run_normal("delay", 20);
        check("delay_min", (st_cyc.size() > last_base) &&
              (st_cyc[last_base] - (last_g + 3) >= 30), 1);

        // No acknowledge.
        rom[0] = 16'h1280; rom[1] = 16'h1101; rom[2] = 16'hFFFF;
        clear_model();
        mode = 1;
        base = st_cyc.size();
        pulse_go(g);
        s = g + 4;
        repeat (ACKT + 2) @(negedge clk);
        check("noack_err_early", seq_err, 0);
        @(negedge clk);
        check("noack_err", seq_err, 1);
        check("noack_start_cyc", (st_cyc.size() > base) ? st_cyc[base] : -1, s);
        check("noack_addr", tbl_addr, 0);
        check("noack_wr", wr_count, 0);
        repeat (40) @(negedge clk);
        check("noack_nstart", st_cyc.size() - base, 1);

        // Stuck busy, failing at entry 1 after a zero-length delay.
        rom[0] = 16'hF000; rom[1] = 16'h3A04; rom[2] = 16'hFFFF;
        clear_model();
        mode = 2;
        blen = 5;
        base = st_cyc.size();
        pulse_go(g);
        s = g + 7;
        repeat (s + 101 - (g + 1)) @(negedge clk);
        check("stuck_err_early", seq_err, 0);
        @(negedge clk);
        check("stuck_err", seq_err, 1);
        check("stuck_start_cyc", (st_cyc.size() > base) ? st_cyc[base] : -1, s);
        check("stuck_addr", tbl_addr, 1);
        check("stuck_wr", wr_count, 0);
        run_normal("recover", 30);

        // External bus owner for 20 cycles, plus an ignored go mid-run.
        rom[0] = 16'h1280; rom[1] = 16'hFFFF;
        mode = 0;
        blen = 25;
        clear_model();
        ext_busy = 1'b1;
        base = st_cyc.size();
        pulse_go(g);
        repeat (8) @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        check("ext_go_addr", tbl_addr, 0);
        check("ext_go_busy", seq_busy, 1);
        repeat (9) @(negedge clk);
        check("ext_no_start", st_cyc.size() - base, 0);
        ext_busy = 1'b0;
        s = g + 20;
        begin
            int c;
            wait_end(3000, c);
            check("ext_done_cyc", c, s + 25 + 2 + GAP + 3);
        end
        check("ext_nstart", st_cyc.size() - base, 1);
        check("ext_start_cyc", (st_cyc.size() > base) ? st_cyc[base] : -1, s);
        check("ext_wr", wr_count, 1);

        // Full table with no end marker.
        rom[0] = 16'h1280; rom[1] = 16'h1101; rom[2] = 16'h3A04; rom[3] = 16'h5505;
        run_normal("four", 10);
        check("four_wr4", wr_count, 4);

        // Async reset mid-transfer.
        clear_model();
        blen = 40;
        pulse_go(g);
        repeat (13) @(negedge clk);
        check("ar_in_xfer", seq_busy, 1);
        #1 rstn = 1'b0;
        #1 check_all_zero("areset");
        @(negedge clk);
        rstn = 1'b1;

        // Randomized tables and transfer lengths.
        for (int it = 0; it < 6; it++) begin
            for (int a = 0; a < 4; a++) begin
                int r;
                r = $urandom_range(0, 9);
                if (r == 0) rom[a] = 16'hFFFF;
                else if (r <= 2) rom[a] = {8'hF0, 8'($urandom_range(0, 3))};
                else rom[a] = {8'($urandom_range(0, 239)), 8'($urandom)};
            end
            run_normal($sformatf("rand%0d", it), $urandom_range(1, 30));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
